// File: rtl/adc_scan_sequencer_pkg.sv
// Shared definitions for the SPI ADC scan sequencer: FSM encoding and SPI frame geometry.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SELECT   = 3'd2,
    ST_XFER     = 3'd3,
    ST_GAP      = 3'd4
  } seq_state_t;

  localparam int FRAME_W      = 16;
  localparam int CMD_CH_OFS   = 11;
  localparam int HALF_PERIODS = 2 * FRAME_W;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Result slot between the scan sequencer and the CPU-side Avalon bridge (1-deep valid/ready).
interface adc_scan_sequencer_if #(
  parameter int CH_W   = 3,
  parameter int DATA_W = 12
);
  logic              res_valid;
  logic              res_ready;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;

  modport master (output res_valid, output res_ch, output res_data, input res_ready);
  modport slave  (input res_valid, input res_ch, input res_data, output res_ready);
endinterface

// File: rtl/adc_scan_sequencer_spi.sv
// SPI mode-0 frame engine: one FRAME_W-bit exchange per start pulse, SCLK half-period of CLK_DIV cycles.
module spi_frame_shifter
  import adc_seq_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] cmd_in,
  input  logic               miso,
  output logic               done,
  output logic [FRAME_W-1:0] rx_out,
  output logic               sclk,
  output logic               mosi,
  output logic               ss
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HP_W  = $clog2(HALF_PERIODS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIODS - 1);

  logic [DIV_W-1:0]   div_cnt_r;
  logic [HP_W-1:0]    half_cnt_r;
  logic [FRAME_W-1:0] tx_sh_r;
  logic               active_r;

  // Frame sequencing; done marks the cycle whose closing edge raises SS.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss         <= 1'b1;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      done       <= 1'b0;
      active_r   <= 1'b0;
      div_cnt_r  <= '0;
      half_cnt_r <= '0;
      tx_sh_r    <= '0;
      rx_out     <= '0;
    end else if (start) begin
      ss         <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= cmd_in[FRAME_W-1];
      tx_sh_r    <= {cmd_in[FRAME_W-2:0], 1'b0};
      div_cnt_r  <= '0;
      half_cnt_r <= '0;
      active_r   <= 1'b1;
      done       <= 1'b0;
    end else if (done) begin
      done <= 1'b0;
      ss   <= 1'b1;
    end else if (active_r) begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r  <= '0;
        sclk       <= ~sclk;
        half_cnt_r <= half_cnt_r + HP_W'(1);
        if (!sclk) begin
          rx_out <= {rx_out[FRAME_W-2:0], miso};
        end else begin
          mosi    <= tx_sh_r[FRAME_W-1];
          tx_sh_r <= {tx_sh_r[FRAME_W-2:0], 1'b0};
        end
        if (half_cnt_r == HP_LAST) begin
          active_r <= 1'b0;
          done     <= 1'b1;
        end else begin
          active_r <= 1'b1;
        end
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans the enabled ADC channels round-robin over SPI and hands each result to the CPU through a 1-deep slot.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int CH_W         = 3,
  parameter int DATA_W       = 12,
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 50,
  parameter int GAP_CYCLES   = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              enable,
  input  logic [NUM_CH-1:0] scan_mask,
  input  logic              adc_reset_req,
  adc_scan_sequencer_if.master res,
  output logic              busy,
  output logic [NUM_CH-1:0] RESET_ADC,
  output logic              SPI_CLOCK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic              SPI_SS
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  seq_state_t         state_r;
  logic [CH_W-1:0]    last_ch_r;
  logic [CH_W-1:0]    xfer_ch_r;
  logic [RST_W-1:0]   rst_cnt_r;
  logic [GAP_W-1:0]   gap_cnt_r;
  logic               rst_pend_r;
  logic [CH_W-1:0]    lo_ch_s;
  logic [CH_W-1:0]    hi_ch_s;
  logic               lo_hit_s;
  logic               hi_hit_s;
  logic [CH_W-1:0]    sel_ch_s;
  logic               start_s;
  logic [FRAME_W-1:0] cmd_s;
  logic               done_s;
  logic [FRAME_W-1:0] rx_s;
  logic               unused_rx_hi_s;
  logic               scan_ok_s;

  assign unused_rx_hi_s = ^rx_s[FRAME_W-1:DATA_W];
  assign scan_ok_s      = enable && (|scan_mask) && !res.res_valid;

  // Round-robin pick: lowest enabled channel above last_ch, else lowest enabled channel overall.
  always_comb begin
    lo_ch_s  = '0;
    hi_ch_s  = '0;
    lo_hit_s = 1'b0;
    hi_hit_s = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (scan_mask[i]) begin
        lo_ch_s  = CH_W'(i);
        lo_hit_s = 1'b1;
        if (i > int'(last_ch_r)) begin
          hi_ch_s  = CH_W'(i);
          hi_hit_s = 1'b1;
        end else begin
          hi_hit_s = hi_hit_s;
        end
      end else begin
        lo_hit_s = lo_hit_s;
      end
    end
    sel_ch_s = hi_hit_s ? hi_ch_s : lo_ch_s;
    start_s  = (state_r == ST_SELECT) && lo_hit_s;
    cmd_s    = FRAME_W'(sel_ch_s) << CMD_CH_OFS;
  end

  spi_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .start  (start_s),
    .cmd_in (cmd_s),
    .miso   (SPI_MISO),
    .done   (done_s),
    .rx_out (rx_s),
    .sclk   (SPI_CLOCK),
    .mosi   (SPI_MOSI),
    .ss     (SPI_SS)
  );

  // Sequencer FSM with reset timer, gap timer and result slot.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_r       <= ST_RST_HOLD;
      busy          <= 1'b1;
      RESET_ADC     <= '1;
      rst_cnt_r     <= '0;
      gap_cnt_r     <= '0;
      rst_pend_r    <= 1'b0;
      last_ch_r     <= CH_W'(NUM_CH - 1);
      xfer_ch_r     <= '0;
      res.res_valid <= 1'b0;
      res.res_ch    <= '0;
      res.res_data  <= '0;
    end else begin
      if (done_s) begin
        res.res_valid <= 1'b1;
        res.res_ch    <= xfer_ch_r;
        res.res_data  <= rx_s[DATA_W-1:0];
        last_ch_r     <= xfer_ch_r;
      end else if (res.res_valid && res.res_ready) begin
        res.res_valid <= 1'b0;
      end

      // A reset request during a scan waits for the frame and its gap to finish.
      if (adc_reset_req && (state_r == ST_SELECT || state_r == ST_XFER || state_r == ST_GAP)) begin
        rst_pend_r <= 1'b1;
      end

      case (state_r)
        ST_RST_HOLD: begin
          if (adc_reset_req) begin
            rst_cnt_r <= '0;
          end else if (rst_cnt_r == RST_LAST) begin
            RESET_ADC <= '0;
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            rst_cnt_r <= rst_cnt_r + RST_W'(1);
          end
        end
        ST_IDLE: begin
          if (adc_reset_req || rst_pend_r) begin
            state_r    <= ST_RST_HOLD;
            RESET_ADC  <= '1;
            rst_cnt_r  <= '0;
            rst_pend_r <= 1'b0;
            busy       <= 1'b1;
          end else if (scan_ok_s) begin
            state_r <= ST_SELECT;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (lo_hit_s) begin
            state_r   <= ST_XFER;
            xfer_ch_r <= sel_ch_s;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_XFER: begin
          if (done_s) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= '0;
          end else begin
            state_r <= ST_XFER;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r != GAP_LAST) begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end else if (rst_pend_r || adc_reset_req) begin
            state_r    <= ST_RST_HOLD;
            RESET_ADC  <= '1;
            rst_cnt_r  <= '0;
            rst_pend_r <= 1'b0;
          end else if (scan_ok_s) begin
            state_r <= ST_SELECT;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_RST_HOLD;
          RESET_ADC <= '1;
          rst_cnt_r <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural SPI ADC returning {4'hC, 12'hA50 + channel}.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

  logic       CLOCK_50      = 1'b0;
  logic       RESET         = 1'b1;
  logic       enable        = 1'b0;
  logic [7:0] scan_mask     = 8'h00;
  logic       adc_reset_req = 1'b0;
  logic       busy;
  logic [7:0] RESET_ADC;
  logic       SPI_CLOCK;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       SPI_SS;

  int checks = 0;
  int errors = 0;

  logic [2:0]  model_ch = 3'd0;
  logic [15:0] adc_word;
  logic [15:0] mosi_cap = 16'h0000;
  int          rise_cnt = 16;

  localparam logic [2:0]  T2_CH   [4] = '{3'd0, 3'd2, 3'd0, 3'd2};
  localparam logic [11:0] T2_DATA [4] = '{12'hA50, 12'hA52, 12'hA50, 12'hA52};
  localparam logic [15:0] T2_CMD  [4] = '{16'h0000, 16'h1000, 16'h0000, 16'h1000};

  adc_scan_sequencer_if #(.CH_W(3), .DATA_W(12)) res_if ();

  adc_scan_sequencer dut (
    .CLOCK_50      (CLOCK_50),
    .RESET         (RESET),
    .enable        (enable),
    .scan_mask     (scan_mask),
    .adc_reset_req (adc_reset_req),
    .res           (res_if),
    .busy          (busy),
    .RESET_ADC     (RESET_ADC),
    .SPI_CLOCK     (SPI_CLOCK),
    .SPI_MOSI      (SPI_MOSI),
    .SPI_MISO      (SPI_MISO),
    .SPI_SS        (SPI_SS)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // ADC model: MSB-first word, bit k presented before the k-th SCLK rise; MOSI captured on rises.
  assign adc_word = {4'hC, 12'hA50 + {9'b0, model_ch}};
  assign SPI_MISO = (rise_cnt < 16) ? adc_word[4'(15 - rise_cnt)] : 1'b0;

  always @(negedge SPI_SS or posedge SPI_CLOCK) begin
    if (SPI_SS === 1'b0 && SPI_CLOCK === 1'b1) begin
      rise_cnt = rise_cnt + 1;
      mosi_cap = {mosi_cap[14:0], SPI_MOSI};
    end else if (SPI_SS === 1'b0) begin
      rise_cnt = 0;
      mosi_cap = 16'h0000;
    end
  end

  // Counts negedge samples until SS equals lvl (bounded).
  task automatic wait_ss(input logic lvl, output int n);
    n = 0;
    @(negedge CLOCK_50);
    while (SPI_SS !== lvl && n < 2000) begin
      n++;
      @(negedge CLOCK_50);
    end
  endtask

  // Counts consecutive samples (current one included) with RESET_ADC all ones.
  task automatic count_adc_reset(output int n, output int ss_bad);
    n = 0;
    ss_bad = 0;
    while (RESET_ADC === 8'hFF && n < 500) begin
      n++;
      if (SPI_SS !== 1'b1) ss_bad++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_reset();
    int n, ss_bad;
    RESET = 1'b1;
    res_if.res_ready = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (RESET_ADC !== 8'hFF) begin errors++; $display("FAIL rst_adc_reset: got %h want ff", RESET_ADC); end
    checks++; if (SPI_SS !== 1'b1) begin errors++; $display("FAIL rst_ss: got %b want 1", SPI_SS); end
    checks++; if (SPI_CLOCK !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", SPI_CLOCK); end
    checks++; if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", SPI_MOSI); end
    checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", res_if.res_valid); end
    checks++; if (res_if.res_ch !== 3'd0) begin errors++; $display("FAIL rst_ch: got %0d want 0", res_if.res_ch); end
    checks++; if (res_if.res_data !== 12'h000) begin errors++; $display("FAIL rst_data: got %h want 000", res_if.res_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    RESET = 1'b0;
    count_adc_reset(n, ss_bad);
    checks++; if (n != 50) begin errors++; $display("FAIL t1_hold_len: got %0d want 50", n); end
    checks++; if (RESET_ADC !== 8'h00) begin errors++; $display("FAIL t1_release: got %h want 00", RESET_ADC); end
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL t1_ss_quiet: got %0d lows want 0", ss_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int n;
    scan_mask = 8'b0000_0101;
    res_if.res_ready = 1'b1;
    model_ch = 3'd0;
    enable = 1'b1;
    wait_ss(1'b0, n);
    checks++; if (n >= 20) begin errors++; $display("FAIL t2_start: got %0d cycles want <20", n); end
    for (int k = 0; k < 4; k++) begin
      wait_ss(1'b1, n);
      checks++; if (n + 1 != 129) begin errors++; $display("FAIL t2_ss_low[%0d]: got %0d want 129", k, n + 1); end
      checks++; if (res_if.res_valid !== 1'b1) begin errors++; $display("FAIL t2_valid[%0d]: got %b want 1", k, res_if.res_valid); end
      checks++; if (res_if.res_ch !== T2_CH[k]) begin errors++; $display("FAIL t2_ch[%0d]: got %0d want %0d", k, res_if.res_ch, T2_CH[k]); end
      checks++; if (res_if.res_data !== T2_DATA[k]) begin errors++; $display("FAIL t2_data[%0d]: got %h want %h", k, res_if.res_data, T2_DATA[k]); end
      checks++; if (mosi_cap !== T2_CMD[k]) begin errors++; $display("FAIL t2_cmd[%0d]: got %h want %h", k, mosi_cap, T2_CMD[k]); end
      if (k == 3) begin
        enable = 1'b0;
      end else begin
        model_ch = T2_CH[k + 1];
        wait_ss(1'b0, n);
        checks++; if (n + 1 < 8) begin errors++; $display("FAIL t2_gap[%0d]: got %0d want >=8", k, n + 1); end
        checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL t2_consumed[%0d]: got %b want 0", k, res_if.res_valid); end
      end
    end
    repeat (20) @(negedge CLOCK_50);
    checks++; if (busy !== 1'b0 || SPI_SS !== 1'b1) begin errors++; $display("FAIL t2_idle: got busy=%b ss=%b want 0/1", busy, SPI_SS); end
  endtask

  task automatic test_backpressure();
    int n, ss_low, lost;
    scan_mask = 8'h01;
    res_if.res_ready = 1'b0;
    model_ch = 3'd0;
    enable = 1'b1;
    wait_ss(1'b0, n);
    wait_ss(1'b1, n);
    checks++; if (res_if.res_valid !== 1'b1 || res_if.res_ch !== 3'd0 || res_if.res_data !== 12'hA50) begin
      errors++; $display("FAIL t3_held: got v=%b ch=%0d d=%h want 1/0/a50", res_if.res_valid, res_if.res_ch, res_if.res_data); end
    ss_low = 0;
    lost = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (SPI_SS !== 1'b1) ss_low++;
      if (res_if.res_valid !== 1'b1 || res_if.res_data !== 12'hA50) lost++;
    end
    checks++; if (ss_low != 0) begin errors++; $display("FAIL t3_ss_stall: got %0d lows want 0", ss_low); end
    checks++; if (lost != 0) begin errors++; $display("FAIL t3_hold: got %0d bad samples want 0", lost); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy: got %b want 0", busy); end
    res_if.res_ready = 1'b1;
    @(negedge CLOCK_50);
    checks++; if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL t3_clear: got %b want 0", res_if.res_valid); end
    wait_ss(1'b0, n);
    checks++; if (n > 4) begin errors++; $display("FAIL t3_restart: got %0d cycles want <=4", n); end
    enable = 1'b0;
    wait_ss(1'b1, n);
    checks++; if (res_if.res_valid !== 1'b1 || res_if.res_data !== 12'hA50) begin
      errors++; $display("FAIL t3_second: got v=%b d=%h want 1/a50", res_if.res_valid, res_if.res_data); end
    repeat (12) @(negedge CLOCK_50);
  endtask

  task automatic test_empty_mask();
    int bad_busy, bad_ss, bad_valid;
    scan_mask = 8'h00;
    res_if.res_ready = 1'b1;
    enable = 1'b1;
    bad_busy = 0;
    bad_ss = 0;
    bad_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b0) bad_busy++;
      if (SPI_SS !== 1'b1) bad_ss++;
      if (res_if.res_valid !== 1'b0) bad_valid++;
    end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL t4_busy: got %0d high want 0", bad_busy); end
    checks++; if (bad_ss != 0) begin errors++; $display("FAIL t4_ss: got %0d low want 0", bad_ss); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL t4_valid: got %0d set want 0", bad_valid); end
    enable = 1'b0;
  endtask

  task automatic test_reset_req_mid_frame();
    int n, ss_bad;
    scan_mask = 8'h08;
    res_if.res_ready = 1'b1;
    model_ch = 3'd3;
    enable = 1'b1;
    wait_ss(1'b0, n);
    checks++; if (n >= 20) begin errors++; $display("FAIL t5_start: got %0d cycles want <20", n); end
    repeat (40) @(negedge CLOCK_50);
    adc_reset_req = 1'b1;
    @(negedge CLOCK_50);
    adc_reset_req = 1'b0;
    wait_ss(1'b1, n);
    checks++; if (res_if.res_valid !== 1'b1 || res_if.res_ch !== 3'd3 || res_if.res_data !== 12'hA53) begin
      errors++; $display("FAIL t5_result: got v=%b ch=%0d d=%h want 1/3/a53", res_if.res_valid, res_if.res_ch, res_if.res_data); end
    checks++; if (mosi_cap !== 16'h1800) begin errors++; $display("FAIL t5_cmd: got %h want 1800", mosi_cap); end
    checks++; if (RESET_ADC !== 8'h00) begin errors++; $display("FAIL t5_not_yet: got %h want 00", RESET_ADC); end
    n = 0;
    while (RESET_ADC !== 8'hFF && n < 100) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n < 8 || n >= 20) begin errors++; $display("FAIL t5_gap_to_reset: got %0d want 8..19", n); end
    enable = 1'b0;
    count_adc_reset(n, ss_bad);
    checks++; if (n != 50) begin errors++; $display("FAIL t5_hold_len: got %0d want 50", n); end
    checks++; if (ss_bad != 0) begin errors++; $display("FAIL t5_ss_quiet: got %0d lows want 0", ss_bad); end
  endtask

  task automatic test_reset_mid_frame();
    int n, ss_bad;
    scan_mask = 8'h01;
    res_if.res_ready = 1'b1;
    model_ch = 3'd0;
    enable = 1'b1;
    wait_ss(1'b0, n);
    n = 0;
    while (rise_cnt < 7 && n < 200) begin
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (rise_cnt != 7) begin errors++; $display("FAIL t6_reach_bit7: got %0d rises want 7", rise_cnt); end
    RESET = 1'b1;
    @(negedge CLOCK_50);
    checks++; if (SPI_SS !== 1'b1 || SPI_CLOCK !== 1'b0 || SPI_MOSI !== 1'b0) begin
      errors++; $display("FAIL t6_abort_spi: got ss=%b sclk=%b mosi=%b want 1/0/0", SPI_SS, SPI_CLOCK, SPI_MOSI); end
    checks++; if (res_if.res_valid !== 1'b0 || res_if.res_data !== 12'h000) begin
      errors++; $display("FAIL t6_slot: got v=%b d=%h want 0/000", res_if.res_valid, res_if.res_data); end
    checks++; if (RESET_ADC !== 8'hFF || busy !== 1'b1) begin
      errors++; $display("FAIL t6_hold: got adc=%h busy=%b want ff/1", RESET_ADC, busy); end
    enable = 1'b0;
    @(negedge CLOCK_50);
    RESET = 1'b0;
    count_adc_reset(n, ss_bad);
    checks++; if (n != 50) begin errors++; $display("FAIL t6_hold_len: got %0d want 50", n); end
    checks++; if (ss_bad != 0 || busy !== 1'b0) begin errors++; $display("FAIL t6_after: got ss_lows=%0d busy=%b want 0/0", ss_bad, busy); end
  endtask

  initial begin
    res_if.res_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_empty_mask();
    test_reset_req_mid_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
